lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store sequencer between the core's memory stage and the word-organised data memory (DEPTH words, word-indexed address, combinational read gated by memread, write on clock edge).
Converts byte-addressed RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
Performs read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
Flags misaligned, out-of-range and illegal-width requests without touching memory.

Parameters:
DEPTH, 64, number of 32-bit words in the data memory; valid word index 0..DEPTH-1
AW, 6, width of the word index driven to the memory (clog2(DEPTH))

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req  input  1  core request valid
we  input  1  1 = store, 0 = load
funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  input  32  byte address
wdata  input  32  store data (LSBs used for B/H)
ready  output  1  controller idle, request accepted when req&&ready
done  output  1  one-cycle completion pulse
rdata  output  32  extended load result, valid when done
err  output  1  qualifies done: request rejected, no memory access
mem_address  output  32  word index to memory, {zeros, addr[AW+1:2]}
mem_wd  output  32  write data to memory
mem_memwrite  output  1  memory write enable
mem_memread  output  1  memory read enable
mem_rd  input  32  memory read data (combinational)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- States: IDLE, READ, WRITE, RESP.
- Accept: in IDLE, ready=1; on req=1 the controller latches we, funct3, addr and wdata. All other states have ready=0, and req is ignored.
- Error check at accept. err is set on any of:
  - misalignment: H/HU with addr[0]=1; W with addr[1:0]!=0;
  - addr[31:2] >= DEPTH;
  - funct3 in {011,110,111};
  - a store with funct3 100 or 101.
- Accept transitions:
  - error -> RESP with err=1;
  - load -> READ;
  - SW -> WRITE;
  - SB/SH -> READ.
- READ (mem_memread=1, mem_address driven):
  - load: select the byte/half at addr[1:0] from mem_rd, sign-extend (B/H) or zero-extend (BU/HU), register into rdata, -> RESP;
  - SB/SH: register mem_rd as the merge base, -> WRITE.
- WRITE (mem_memwrite=1):
  - SW: mem_wd = wdata.
  - SB/SH: mem_wd = base with lane addr[1:0] (byte) or addr[1] (half) replaced by wdata[7:0]/wdata[15:0]; all other bytes unchanged.
  - Next state: RESP.
- RESP: done=1 for exactly one cycle, err as latched, then -> IDLE.
- Earliest re-accept: the cycle after RESP.
- Latency, counting the accept edge as cycle 0:
  - load: done in cycle 2;
  - SW: done in cycle 2;
  - SB/SH: done in cycle 3;
  - error: done in cycle 1.
- Outputs outside their states:
  - mem_memread=0 and mem_memwrite=0 except in READ/WRITE respectively;
  - mem_address and mem_wd are don't-care when their enable is low; drive 0.
- rdata holds its last value until the next load completes.
- rdata is 0 after stores and errors.
- Reset values: state=IDLE, ready=1, done=0, err=0, rdata=0, all mem_* outputs 0.
- Reset mid-operation: the operation is abandoned. mem_memwrite is gated by !rst, so no write occurs in a reset cycle. No done is issued.
- Only one outstanding request. Back-to-back loads and stores to the same word see the prior write, because the write completes before RESP.

Test Plan:
- Reset, then SW addr=0x08 wdata=0xDEADBEEF; LW addr=0x08 -> word 2 written; load done in cycle 2 with rdata=0xDEADBEEF, err=0.
- With word 2=0xDEADBEEF: SB addr=0x09 wdata=0x55 -> done in cycle 3 with exactly one write, word 2=0xDEAD55EF; LBU 0x0B -> rdata=0x000000DE; LB 0x0B -> rdata=0xFFFFFFDE.
- SH addr=0x0A wdata=0x8001; LH 0x0A -> rdata=0xFFFF8001; LHU 0x0A -> rdata=0x00008001.
- Errors, each with done and err in cycle 1 and mem_memread/mem_memwrite never asserted:
  - LW 0x06;
  - LH 0x05;
  - SW 0x100 with DEPTH=64;
  - funct3=011;
  - store with funct3=100.
- Hold req=1 continuously -> ready low in READ/WRITE/RESP, no new accept until IDLE, exactly one done per transaction.
- Assert rst during WRITE of an SW -> no mem_memwrite in that cycle, no done, ready=1 the next cycle; a following LW returns the memory-reset value 0.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: byte-addressed RV32I loads/stores to a word memory.
// Ports: clk/rst, core req/we/funct3/addr/wdata -> ready/done/rdata/err; mem_* to data memory.
module lsu_mem_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wd,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     base_q, base_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            bad_f3, misal, oor, req_err;
  logic [31:0]     shifted, ld_val, merged, word_idx;

  always_comb begin
    bad_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11)
          || (we && funct3[2]);
    misal = ((funct3[1:0] == 2'b01) && addr[0])
         || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    oor = addr[31:2] >= 30'(DEPTH);
    req_err = bad_f3 || misal || oor;
  end

  assign word_idx = 32'(addr_q[AW+1:2]);

  // Bring the addressed lane down to bit 0, then extend.
  assign shifted = mem_rd >> {addr_q[1:0], 3'b000};

  always_comb begin
    unique case (f3_q)
      3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_val = {24'd0, shifted[7:0]};
      3'b101:  ld_val = {16'd0, shifted[15:0]};
      default: ld_val = mem_rd;
    endcase
  end

  // Sub-word store: overwrite one lane of the word read in READ.
  always_comb begin
    merged = base_q;
    if (f3_q[0]) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    base_d       = base_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    ready        = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    mem_address  = 32'd0;
    mem_wd       = 32'd0;
    mem_memwrite = 1'b0;
    mem_memread  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          we_d    = we;
          f3_d    = funct3;
          addr_d  = addr[AW+1:0];
          wdata_d = wdata;
          err_d   = req_err;
          if (req_err) begin
            rdata_d = 32'd0;
            state_d = RESP;
          end else if (we && (funct3 == 3'b010)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        mem_memread = 1'b1;
        mem_address = word_idx;
        if (we_q) begin
          base_d  = mem_rd;
          state_d = WRITE;
        end else begin
          rdata_d = ld_val;
          state_d = RESP;
        end
      end
      WRITE: begin
        mem_memwrite = !rst;
        mem_address  = word_idx;
        mem_wd       = (f3_q == 3'b010) ? wdata_q : merged;
        rdata_d      = 32'd0;
        state_d      = RESP;
      end
      RESP: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      base_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      base_q  <= base_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: byte-array reference model, directed and random ops.
// Drives inputs on negedge, samples outputs on negedge.
module tb_lsu_mem_ctrl;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_address;
  logic [31:0] mem_wd;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [DEPTH];
  logic [7:0]  rm  [4*DEPTH];

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done),
    .rdata(rdata), .err(err), .mem_address(mem_address),
    .mem_wd(mem_wd), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_rd(mem_rd)
  );

  assign mem_rd = mem_memread ? mem[mem_address[AW-1:0]] : 32'hA5A5_A5A5;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (mem_memwrite) begin
      mem[mem_address[AW-1:0]] <= mem_wd;
    end
  end

  function automatic logic [31:0] ref_word(input int w);
    return {rm[4*w+3], rm[4*w+2], rm[4*w+1], rm[4*w]};
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < 4*DEPTH; i++) rm[i] = 8'd0;
  endtask

  // Runs one request through the DUT and checks it against the byte model.
  task automatic run_op(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got_rd, output logic got_err);
    int size, lat, reads, writes, e_lat, e_reads, e_writes, c;
    logic e_err, got, sgn;
    logic [31:0] e_rd, hi;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    sgn  = !f3[2];
    e_err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
         || (w && f3[2]) || ((a % size) != 0) || ((a / 4) >= DEPTH);
    e_rd = 32'd0;
    if (!e_err && !w) begin
      for (int i = 0; i < size; i++) e_rd = e_rd | (32'(rm[a+i]) << (8*i));
      hi = 32'd1 << (8*size - 1);
      if (size < 4 && sgn && (e_rd & hi) != 0)
        e_rd = e_rd - (hi << 1);
    end
    e_lat    = e_err ? 1 : (w && size < 4) ? 3 : 2;
    e_reads  = e_err ? 0 : (w && size == 4) ? 0 : 1;
    e_writes = (!e_err && w) ? 1 : 0;
    if (!e_err && w)
      for (int i = 0; i < size; i++) rm[a+i] = wd[8*i +: 8];

    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_req got %b want 1", ready);
    end
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    got = 1'b0; lat = 0; reads = 0; writes = 0; got_rd = 32'hx; got_err = 1'bx;
    c = 0;
    while (!got && c < 8) begin
      @(negedge clk);
      c++;
      if (mem_memread)  reads++;
      if (mem_memwrite) writes++;
      if (done) begin
        got = 1'b1; lat = c; got_rd = rdata; got_err = err;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout f3=%0d a=%h got none want done", f3, a);
    end
    checks++;
    if (lat != e_lat || got_err !== e_err || got_rd !== e_rd) begin
      errors++;
      $display("FAIL op we=%b f3=%0d a=%h lat/err/rd got %0d/%b/%h want %0d/%b/%h",
               w, f3, a, lat, got_err, got_rd, e_lat, e_err, e_rd);
    end
    checks++;
    if (reads != e_reads || writes != e_writes) begin
      errors++;
      $display("FAIL memcycles f3=%0d a=%h rd/wr got %0d/%0d want %0d/%0d",
               f3, a, reads, writes, e_reads, e_writes);
    end
    if (!e_err) begin
      checks++;
      if (mem[a/4] !== ref_word(a/4)) begin
        errors++;
        $display("FAIL memword idx=%0d got %h want %h", a/4, mem[a/4], ref_word(a/4));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || rdata !== e_rd) begin
      errors++;
      $display("FAIL after_done done/rdata got %b/%h want 0/%h", done, rdata, e_rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    ref_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready, done, err, mem_memread, mem_memwrite} !== 5'b10000 ||
        rdata !== 32'd0 || mem_address !== 32'd0 || mem_wd !== 32'd0) begin
      errors++;
      $display("FAIL reset rdy/dn/err/rd/wr got %b%b%b%b%b rdata %h want 10000 0",
               ready, done, err, mem_memread, mem_memwrite, rdata);
    end
  endtask

  task automatic test_word();
    logic [31:0] r; logic e;
    run_op(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, r, e);
    run_op(1'b0, 3'b010, 32'h08, 32'h0, r, e);
    checks++;
    if (r !== 32'hDEADBEEF || e !== 1'b0) begin
      errors++;
      $display("FAIL lw_word got %h/%b want deadbeef/0", r, e);
    end
  endtask

  task automatic test_byte();
    logic [31:0] r; logic e;
    run_op(1'b1, 3'b000, 32'h09, 32'h55, r, e);
    checks++;
    if (mem[2] !== 32'hDEAD55EF) begin
      errors++;
      $display("FAIL sb_merge got %h want dead55ef", mem[2]);
    end
    run_op(1'b0, 3'b100, 32'h0B, 32'h0, r, e);
    checks++;
    if (r !== 32'h000000DE) begin
      errors++;
      $display("FAIL lbu got %h want 000000de", r);
    end
    run_op(1'b0, 3'b000, 32'h0B, 32'h0, r, e);
    checks++;
    if (r !== 32'hFFFFFFDE) begin
      errors++;
      $display("FAIL lb got %h want ffffffde", r);
    end
  endtask

  task automatic test_half();
    logic [31:0] r; logic e;
    run_op(1'b1, 3'b001, 32'h0A, 32'h8001, r, e);
    run_op(1'b0, 3'b001, 32'h0A, 32'h0, r, e);
    checks++;
    if (r !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL lh got %h want ffff8001", r);
    end
    run_op(1'b0, 3'b101, 32'h0A, 32'h0, r, e);
    checks++;
    if (r !== 32'h00008001) begin
      errors++;
      $display("FAIL lhu got %h want 00008001", r);
    end
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e;
    logic [35:0] tbl [5];
    tbl[0] = {1'b0, 3'b010, 32'h06};
    tbl[1] = {1'b0, 3'b001, 32'h05};
    tbl[2] = {1'b1, 3'b010, 32'h100};
    tbl[3] = {1'b0, 3'b011, 32'h00};
    tbl[4] = {1'b1, 3'b100, 32'h04};
    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i][35], tbl[i][34:32], tbl[i][31:0], 32'h1234_5678, r, e);
      checks++;
      if (e !== 1'b1 || r !== 32'd0) begin
        errors++;
        $display("FAIL err_case%0d err/rdata got %b/%h want 1/0", i, e, r);
      end
    end
  endtask

  task automatic test_hold_req();
    int dones, accepts, bad;
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h08; wdata = 32'd0;
    dones = 0; accepts = 0; bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (ready && req) accepts++;
      if (done) dones++;
      if (ready && (done || mem_memread || mem_memwrite)) bad++;
      @(negedge clk);
    end
    req = 1'b0;
    checks++;
    if (dones != 4 || accepts != 4 || bad != 0) begin
      errors++;
      $display("FAIL hold_req dones/accepts/bad got %0d/%0d/%0d want 4/4/0",
               dones, accepts, bad);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] r; logic e;
    int dn;
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h10; wdata = 32'h1234_5678;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_memwrite !== 1'b1) begin
      errors++;
      $display("FAIL sw_write_cycle memwrite got %b want 1", mem_memwrite);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_memwrite !== 1'b0) begin
      errors++;
      $display("FAIL rst_gate memwrite got %b want 0", mem_memwrite);
    end
    ref_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++;
    if (dn != 0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_abandon dones/ready got %0d/%b want 0/1", dn, ready);
    end
    run_op(1'b0, 3'b010, 32'h10, 32'h0, r, e);
    checks++;
    if (r !== 32'd0) begin
      errors++;
      $display("FAIL lw_after_rst got %h want 0", r);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, a;
    logic e, w;
    logic [2:0] f3;
    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 4*DEPTH + 7));
      run_op(w, f3, a, $urandom, r, e);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_hold_req();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
